// File: rtl/axi_burst_split_master.sv
// AXI4 master that splits one user command into INCR bursts capped at MAX_BURST
// beats and never crossing a 4 KB boundary; one burst in flight at a time.
module axi_burst_split_master #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned LEN_W     = 12,
  parameter int unsigned MAX_BURST = 256
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  // user command
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_w_r,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [LEN_W-1:0]      cmd_beats,
  // user write stream
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [DATA_W/8-1:0]   wr_strb,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  // user read stream
  output logic [DATA_W-1:0]     rd_data,
  output logic [1:0]            rd_resp,
  output logic                  rd_last,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  // completion
  output logic                  done,
  output logic [1:0]            status,
  // AXI write address
  output logic [ADDR_W-1:0]     m_axi_awaddr,
  output logic [7:0]            m_axi_awlen,
  output logic [2:0]            m_axi_awsize,
  output logic [1:0]            m_axi_awburst,
  output logic                  m_axi_awvalid,
  input  logic                  m_axi_awready,
  // AXI write data
  output logic [DATA_W-1:0]     m_axi_wdata,
  output logic [DATA_W/8-1:0]   m_axi_wstrb,
  output logic                  m_axi_wlast,
  output logic                  m_axi_wvalid,
  input  logic                  m_axi_wready,
  // AXI write response
  input  logic [1:0]            m_axi_bresp,
  input  logic                  m_axi_bvalid,
  output logic                  m_axi_bready,
  // AXI read address
  output logic [ADDR_W-1:0]     m_axi_araddr,
  output logic [7:0]            m_axi_arlen,
  output logic [2:0]            m_axi_arsize,
  output logic [1:0]            m_axi_arburst,
  output logic                  m_axi_arvalid,
  input  logic                  m_axi_arready,
  // AXI read data
  input  logic [DATA_W-1:0]     m_axi_rdata,
  input  logic [1:0]            m_axi_rresp,
  input  logic                  m_axi_rlast,
  input  logic                  m_axi_rvalid,
  output logic                  m_axi_rready
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned SZ_W   = $clog2(STRB_W);
  localparam int unsigned CNT_W  = LEN_W + 1;
  localparam int unsigned MW     = (CNT_W > 13) ? CNT_W : 13;

  typedef enum logic [2:0] {
    S_IDLE, S_CALC, S_AW, S_W, S_B, S_AR, S_R, S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic                w_r_q, w_r_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [CNT_W-1:0]    blen_q, blen_d;
  logic [7:0]          len_q, len_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [1:0]          status_q, status_d;

  logic [12:0]         room_c;
  logic [MW-1:0]       to4k_c, blen_c;
  logic [ADDR_W-1:0]   addr_nxt_c;
  logic [CNT_W-1:0]    rem_nxt_c;
  logic                last_beat_c;

  // EXOKAY ranks with OKAY; otherwise the numerically larger code is worse
  function automatic logic [1:0] resp_max(input logic [1:0] cur, input logic [1:0] r);
    logic [1:0] e;
    e = (r == 2'b01) ? 2'b00 : r;
    return (e > cur) ? e : cur;
  endfunction

  assign m_axi_awaddr  = addr_q;
  assign m_axi_awlen   = len_q;
  assign m_axi_awsize  = 3'(SZ_W);
  assign m_axi_awburst = 2'b01;
  assign m_axi_araddr  = addr_q;
  assign m_axi_arlen   = len_q;
  assign m_axi_arsize  = 3'(SZ_W);
  assign m_axi_arburst = 2'b01;
  assign m_axi_wdata   = wr_data;
  assign m_axi_wstrb   = wr_strb;
  assign rd_data       = m_axi_rdata;
  assign rd_resp       = m_axi_rresp;
  assign status        = status_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= S_IDLE;
      w_r_q    <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      blen_q   <= '0;
      len_q    <= '0;
      beat_q   <= '0;
      status_q <= '0;
    end else begin
      state_q  <= state_d;
      w_r_q    <= w_r_d;
      addr_q   <= addr_d;
      rem_q    <= rem_d;
      blen_q   <= blen_d;
      len_q    <= len_d;
      beat_q   <= beat_d;
      status_q <= status_d;
    end
  end

  // Next-state, burst sizing and phase-gated stream/AXI handshakes
  always_comb begin
    state_d  = state_q;
    w_r_d    = w_r_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    blen_d   = blen_q;
    len_d    = len_q;
    beat_d   = beat_q;
    status_d = status_q;

    cmd_ready     = 1'b0;
    m_axi_awvalid = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_wlast   = 1'b0;
    wr_ready      = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_rready  = 1'b0;
    rd_valid      = 1'b0;
    rd_last       = 1'b0;
    done          = 1'b0;

    room_c = 13'h1000 - 13'(addr_q[11:0]);
    to4k_c = MW'(room_c >> SZ_W);
    blen_c = MW'(rem_q);
    if (blen_c > MW'(MAX_BURST)) blen_c = MW'(MAX_BURST);
    if (blen_c > to4k_c)         blen_c = to4k_c;

    addr_nxt_c  = addr_q + (ADDR_W'(blen_q) << SZ_W);
    rem_nxt_c   = rem_q - blen_q;
    last_beat_c = (beat_q == CNT_W'(len_q));

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_r_d    = cmd_w_r;
          addr_d   = cmd_addr & ~ADDR_W'(STRB_W - 1);
          rem_d    = CNT_W'(cmd_beats) + CNT_W'(1);
          status_d = '0;
          state_d  = S_CALC;
        end
      end
      S_CALC: begin
        blen_d  = CNT_W'(blen_c);
        len_d   = 8'(blen_c - MW'(1));
        beat_d  = '0;
        state_d = w_r_q ? S_AR : S_AW;
      end
      S_AW: begin
        m_axi_awvalid = 1'b1;
        if (m_axi_awready) state_d = S_W;
      end
      S_W: begin
        m_axi_wvalid = wr_valid;
        wr_ready     = m_axi_wready;
        m_axi_wlast  = last_beat_c;
        if (wr_valid && m_axi_wready) begin
          beat_d = beat_q + CNT_W'(1);
          if (last_beat_c) state_d = S_B;
        end
      end
      S_B: begin
        m_axi_bready = 1'b1;
        if (m_axi_bvalid) begin
          status_d = resp_max(status_q, m_axi_bresp);
          addr_d   = addr_nxt_c;
          rem_d    = rem_nxt_c;
          state_d  = (rem_nxt_c == '0) ? S_DONE : S_CALC;
        end
      end
      S_AR: begin
        m_axi_arvalid = 1'b1;
        if (m_axi_arready) state_d = S_R;
      end
      S_R: begin
        rd_valid     = m_axi_rvalid;
        m_axi_rready = rd_ready;
        rd_last      = m_axi_rlast && (rem_q == blen_q);
        if (m_axi_rvalid && rd_ready) begin
          status_d = resp_max(status_q, m_axi_rresp);
          if (m_axi_rlast) begin
            addr_d  = addr_nxt_c;
            rem_d   = rem_nxt_c;
            state_d = (rem_nxt_c == '0) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE: begin
        done     = 1'b1;
        status_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_burst_split_master.sv
// Randomized bench: AXI slave + user-stream agent with a burst-splitting reference model.
module tb_axi_burst_split_master;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 64;
  localparam int LEN_W     = 12;
  localparam int MAX_BURST = 256;

  logic aclk, aresetn;
  logic cmd_valid, cmd_ready, cmd_w_r;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_beats;
  logic [DATA_W-1:0] wr_data;
  logic [7:0]        wr_strb;
  logic wr_valid, wr_ready;
  logic [DATA_W-1:0] rd_data;
  logic [1:0]        rd_resp;
  logic rd_last, rd_valid, rd_ready, done;
  logic [1:0] status;
  logic [ADDR_W-1:0] m_axi_awaddr, m_axi_araddr;
  logic [7:0] m_axi_awlen, m_axi_arlen;
  logic [2:0] m_axi_awsize, m_axi_arsize;
  logic [1:0] m_axi_awburst, m_axi_arburst;
  logic m_axi_awvalid, m_axi_awready, m_axi_arvalid, m_axi_arready;
  logic [DATA_W-1:0] m_axi_wdata, m_axi_rdata;
  logic [7:0] m_axi_wstrb;
  logic m_axi_wlast, m_axi_wvalid, m_axi_wready;
  logic [1:0] m_axi_bresp, m_axi_rresp;
  logic m_axi_bvalid, m_axi_bready;
  logic m_axi_rlast, m_axi_rvalid, m_axi_rready;

  axi_burst_split_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_BURST(MAX_BURST)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_w_r(cmd_w_r), .cmd_addr(cmd_addr), .cmd_beats(cmd_beats),
    .wr_data(wr_data), .wr_strb(wr_strb), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_resp(rd_resp), .rd_last(rd_last), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .done(done), .status(status),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen), .m_axi_awsize(m_axi_awsize),
    .m_axi_awburst(m_axi_awburst), .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
    .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
    .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .m_axi_arsize(m_axi_arsize),
    .m_axi_arburst(m_axi_arburst), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp), .m_axi_rlast(m_axi_rlast),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int vectors = 0;
  int miscompares = 0;

  // test configuration
  int          wait_pct = 0;
  bit          toggle_rd = 0;
  bit          rresp_rand = 0;
  bit          w_mode = 0;
  int          total = 0;
  logic [31:0] start_addr = '0;
  logic [31:0] seed = 32'h1234_5678;
  logic [1:0]  bresp_tab [32];

  // reference model output and observed bursts
  logic [31:0] exp_addr_q[$];
  int          exp_len_q[$];
  logic [31:0] obs_addr_q[$];
  int          obs_len_q[$];

  // agent state
  bit in_w, in_r, b_pend;
  int b_wait, w_len, w_cnt, w_total, wr_sent, r_left, rd_cnt, b_idx;
  logic [31:0] r_addr;
  logic [1:0]  acc_stat;
  int done_cnt = 0, d0 = 0, cyc = 0, done_cyc, b_cyc, rl_cyc;
  logic [1:0] done_stat;
  bit aw_f, w_f, wr_f, b_f, ar_f, r_f, rd_f;

  function automatic logic [63:0] wpat(input int i);
    return {seed ^ 32'(i), 32'(i) * 32'h9E37_79B9};
  endfunction
  function automatic logic [7:0] spat(input int i);
    return 8'(i * 37 + 5);
  endfunction
  function automatic logic [63:0] rpat(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a};
  endfunction
  function automatic bit rnd();
    return $urandom_range(99) >= wait_pct;
  endfunction
  function automatic logic [1:0] worse(input logic [1:0] cur, input logic [1:0] r);
    int e;
    e = (r == 2'd1) ? 0 : int'(r);
    return (e > int'(cur)) ? 2'(e) : cur;
  endfunction

  // Reference split: min(remaining, MAX_BURST, beats to next 4 KB line), address wraps at 2^32
  task automatic build_bursts(input logic [31:0] a, input int n);
    int rem, to4k, b;
    logic [31:0] ad;
    exp_addr_q.delete();
    exp_len_q.delete();
    ad  = a & ~32'h7;
    rem = n;
    while (rem > 0) begin
      to4k = (4096 - int'(ad[11:0])) / 8;
      b = rem;
      if (b > MAX_BURST) b = MAX_BURST;
      if (b > to4k) b = to4k;
      exp_addr_q.push_back(ad);
      exp_len_q.push_back(b - 1);
      ad  = ad + 32'(b * 8);
      rem = rem - b;
    end
  endtask

  function automatic bit bursts_match();
    if (obs_addr_q.size() != exp_addr_q.size()) return 0;
    foreach (exp_addr_q[i])
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_len_q[i] != exp_len_q[i]) return 0;
    return 1;
  endfunction

  // Slave + user-stream agent: drive at negedge, sample handshakes 1 ns later
  initial begin
    {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
    m_axi_bresp = '0; m_axi_rresp = '0; m_axi_rdata = '0;
    wr_valid = 0; wr_data = '0; wr_strb = '0; rd_ready = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        in_w = 0; in_r = 0; b_pend = 0; r_left = 0;
        {m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_arready, m_axi_rvalid, m_axi_rlast} = '0;
        wr_valid = 0; rd_ready = 0;
        continue;
      end
      m_axi_awready = rnd();
      m_axi_arready = rnd();
      m_axi_wready  = rnd();
      if (b_pend && b_wait > 0) begin
        b_wait--; m_axi_bvalid = 0;
      end else if (b_pend) begin
        m_axi_bvalid = 1; m_axi_bresp = bresp_tab[b_idx % 32];
      end else m_axi_bvalid = 0;
      if (!(m_axi_rvalid && !r_f)) begin
        if (r_left > 0 && rnd()) begin
          m_axi_rvalid = 1; m_axi_rdata = rpat(r_addr); m_axi_rlast = (r_left == 1);
          m_axi_rresp = rresp_rand ? 2'($urandom_range(3)) : 2'd0;
        end else begin
          m_axi_rvalid = 0; m_axi_rlast = 0;
        end
      end
      if (!(wr_valid && !wr_f)) begin
        if (w_mode && wr_sent < total && rnd()) begin
          wr_valid = 1; wr_data = wpat(wr_sent); wr_strb = spat(wr_sent);
        end else wr_valid = 0;
      end
      rd_ready = toggle_rd ? ~rd_ready : rnd();
      #1;
      if (!aresetn) continue;
      cyc++;
      // phase-gated pass-through of stream handshakes
      vectors++; if (m_axi_wvalid !== (in_w & wr_valid)) begin miscompares++; $display("FAIL wvalid_gate cyc=%0d got=%b exp=%b", cyc, m_axi_wvalid, in_w & wr_valid); end
      vectors++; if (wr_ready !== (in_w & m_axi_wready)) begin miscompares++; $display("FAIL wr_ready_gate cyc=%0d got=%b exp=%b", cyc, wr_ready, in_w & m_axi_wready); end
      vectors++; if (m_axi_bready !== b_pend) begin miscompares++; $display("FAIL bready_gate cyc=%0d got=%b exp=%b", cyc, m_axi_bready, b_pend); end
      vectors++; if (rd_valid !== (in_r & m_axi_rvalid)) begin miscompares++; $display("FAIL rd_valid_gate cyc=%0d got=%b exp=%b", cyc, rd_valid, in_r & m_axi_rvalid); end
      vectors++; if (m_axi_rready !== (in_r & rd_ready)) begin miscompares++; $display("FAIL rready_gate cyc=%0d got=%b exp=%b", cyc, m_axi_rready, in_r & rd_ready); end
      aw_f = m_axi_awvalid & m_axi_awready;
      w_f  = m_axi_wvalid & m_axi_wready;
      wr_f = wr_valid & wr_ready;
      b_f  = m_axi_bvalid & m_axi_bready;
      ar_f = m_axi_arvalid & m_axi_arready;
      r_f  = m_axi_rvalid & m_axi_rready;
      rd_f = rd_valid & rd_ready;
      if (aw_f) begin
        obs_addr_q.push_back(m_axi_awaddr); obs_len_q.push_back(int'(m_axi_awlen));
        in_w = 1; w_len = int'(m_axi_awlen); w_cnt = 0;
        vectors++; if (m_axi_awsize !== 3'd3 || m_axi_awburst !== 2'b01) begin miscompares++; $display("FAIL aw_size_burst got=%0d/%0d exp=3/1", m_axi_awsize, m_axi_awburst); end
      end
      if (w_f) begin
        vectors++; if (m_axi_wdata !== wpat(w_total) || m_axi_wstrb !== spat(w_total)) begin miscompares++; $display("FAIL wdata beat=%0d got=%h/%h exp=%h/%h", w_total, m_axi_wdata, m_axi_wstrb, wpat(w_total), spat(w_total)); end
        vectors++; if (m_axi_wlast !== (w_cnt == w_len)) begin miscompares++; $display("FAIL wlast beat=%0d got=%b exp=%b", w_cnt, m_axi_wlast, w_cnt == w_len); end
        w_total++;
        if (w_cnt == w_len) begin
          in_w = 0; b_pend = 1; b_wait = (wait_pct == 0) ? 0 : $urandom_range(3);
        end
        w_cnt++;
      end
      if (wr_f) wr_sent++;
      if (b_f) begin
        acc_stat = worse(acc_stat, m_axi_bresp); b_pend = 0; b_idx++; b_cyc = cyc;
      end
      if (ar_f) begin
        obs_addr_q.push_back(m_axi_araddr); obs_len_q.push_back(int'(m_axi_arlen));
        in_r = 1; r_left = int'(m_axi_arlen) + 1; r_addr = m_axi_araddr;
        vectors++; if (m_axi_arsize !== 3'd3 || m_axi_arburst !== 2'b01) begin miscompares++; $display("FAIL ar_size_burst got=%0d/%0d exp=3/1", m_axi_arsize, m_axi_arburst); end
      end
      if (rd_f) begin
        vectors++; if (rd_data !== rpat(start_addr + 32'(rd_cnt * 8))) begin miscompares++; $display("FAIL rd_data beat=%0d got=%h exp=%h", rd_cnt, rd_data, rpat(start_addr + 32'(rd_cnt * 8))); end
        vectors++; if (rd_last !== (rd_cnt == total - 1)) begin miscompares++; $display("FAIL rd_last beat=%0d got=%b exp=%b", rd_cnt, rd_last, rd_cnt == total - 1); end
        vectors++; if (rd_resp !== m_axi_rresp) begin miscompares++; $display("FAIL rd_resp beat=%0d got=%0d exp=%0d", rd_cnt, rd_resp, m_axi_rresp); end
        acc_stat = worse(acc_stat, m_axi_rresp);
        rd_cnt++;
      end
      if (r_f) begin
        r_addr = r_addr + 32'd8; r_left--;
        if (m_axi_rlast) begin in_r = 0; rl_cyc = cyc; end
      end
      if (done === 1'b1) begin
        done_cnt++; done_stat = status; done_cyc = cyc;
      end
    end
  end

  task automatic start_cmd(input bit w_r, input logic [31:0] a, input int beats_m1, output bit acc);
    int k;
    build_bursts(a, beats_m1 + 1);
    obs_addr_q.delete(); obs_len_q.delete();
    total = beats_m1 + 1; start_addr = a & ~32'h7;
    wr_sent = 0; w_total = 0; rd_cnt = 0; b_idx = 0; acc_stat = '0; d0 = done_cnt;
    w_mode = !w_r;
    @(negedge aclk);
    cmd_valid = 1; cmd_w_r = w_r; cmd_addr = a; cmd_beats = LEN_W'(beats_m1);
    #2;
    k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin @(negedge aclk); #2; k++; end
    acc = (cmd_ready === 1'b1);
    @(negedge aclk);
    cmd_valid = 0;
    #3;
  endtask

  task automatic run_cmd(input bit w_r, input logic [31:0] a, input int beats_m1, output bit ok);
    int k;
    bit acc;
    start_cmd(w_r, a, beats_m1, acc);
    k = 0;
    while (done_cnt == d0 && k < 20 * (beats_m1 + 1) + 200) begin @(negedge aclk); #3; k++; end
    ok = acc && (done_cnt != d0);
    repeat (3) begin @(negedge aclk); #3; end
    w_mode = 0;
  endtask

  task automatic test_reset();
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL reset_cmd_ready got=%b exp=1", cmd_ready); end
    vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid, done} !== 8'h00) begin
      miscompares++; $display("FAIL reset_valids got=%b exp=00000000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid, done}); end
    vectors++; if (status !== 2'd0 || m_axi_awaddr !== 32'd0 || m_axi_awlen !== 8'd0 || m_axi_araddr !== 32'd0) begin
      miscompares++; $display("FAIL reset_regs got=st%0d aw%h len%0d ar%h exp=all 0", status, m_axi_awaddr, m_axi_awlen, m_axi_araddr); end
  endtask

  task automatic test_write_simple();
    bit ok;
    wait_pct = 0; bresp_tab[0] = 2'd0;
    run_cmd(1'b0, 32'h0, 3, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_simple_done got=timeout exp=done"); end
    vectors++; if (!bursts_match()) begin miscompares++; $display("FAIL wr_simple_bursts got=%0d bursts exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    vectors++; if (w_total != 4) begin miscompares++; $display("FAIL wr_simple_beats got=%0d exp=4", w_total); end
    vectors++; if (done_cyc != b_cyc + 1) begin miscompares++; $display("FAIL wr_simple_done_lat got=%0d exp=%0d", done_cyc, b_cyc + 1); end
    vectors++; if (done_stat !== 2'd0 || done_cnt != d0 + 1) begin miscompares++; $display("FAIL wr_simple_status got=%0d/%0d exp=0/1", done_stat, done_cnt - d0); end
  endtask

  task automatic test_write_4k();
    bit ok;
    wait_pct = 20; bresp_tab[0] = 2'd0; bresp_tab[1] = 2'd1;
    run_cmd(1'b0, 32'h0FF0, 7, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL wr_4k_done got=timeout exp=done"); end
    vectors++; if (!bursts_match() || obs_addr_q.size() != 2) begin miscompares++; $display("FAIL wr_4k_bursts got=%0d bursts exp=2", obs_addr_q.size()); end
    vectors++; if (w_total != 8 || wr_sent != 8) begin miscompares++; $display("FAIL wr_4k_beats got=%0d/%0d exp=8", w_total, wr_sent); end
    vectors++; if (done_cnt != d0 + 1 || done_stat !== 2'd0) begin miscompares++; $display("FAIL wr_4k_done_once got=%0d st=%0d exp=1 st=0", done_cnt - d0, done_stat); end
  endtask

  task automatic test_read_long();
    bit ok;
    wait_pct = 0; rresp_rand = 0;
    run_cmd(1'b1, 32'h0, 599, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_long_done got=timeout exp=done"); end
    vectors++; if (!bursts_match() || obs_addr_q.size() != 3) begin miscompares++; $display("FAIL rd_long_bursts got=%0d bursts exp=3", obs_addr_q.size()); end
    vectors++; if (rd_cnt != 600) begin miscompares++; $display("FAIL rd_long_beats got=%0d exp=600", rd_cnt); end
    vectors++; if (done_cyc != rl_cyc + 1 || done_stat !== 2'd0) begin miscompares++; $display("FAIL rd_long_done got=cyc%0d st%0d exp=cyc%0d st0", done_cyc, done_stat, rl_cyc + 1); end
  endtask

  task automatic test_read_toggle();
    bit ok;
    wait_pct = 0; toggle_rd = 1;
    run_cmd(1'b1, 32'h0FC0, 39, ok);
    toggle_rd = 0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL rd_toggle_done got=timeout exp=done"); end
    vectors++; if (!bursts_match()) begin miscompares++; $display("FAIL rd_toggle_bursts got=%0d bursts exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    vectors++; if (rd_cnt != 40) begin miscompares++; $display("FAIL rd_toggle_beats got=%0d exp=40", rd_cnt); end
  endtask

  task automatic test_slverr();
    bit ok;
    wait_pct = 10; bresp_tab[0] = 2'd2; bresp_tab[1] = 2'd0;
    run_cmd(1'b0, 32'h0FF0, 7, ok);
    vectors++; if (!ok) begin miscompares++; $display("FAIL slverr_done got=timeout exp=done"); end
    vectors++; if (done_stat !== 2'b10) begin miscompares++; $display("FAIL slverr_status got=%0d exp=2", done_stat); end
    bresp_tab[0] = 2'd0;
    run_cmd(1'b0, 32'h0, 0, ok);
    vectors++; if (!ok || done_stat !== 2'b00) begin miscompares++; $display("FAIL status_cleared got=%0d ok=%b exp=0", done_stat, ok); end
  endtask

  task automatic test_reset_midburst();
    bit acc, ok;
    int k;
    wait_pct = 0; bresp_tab[0] = 2'd0;
    start_cmd(1'b0, 32'h100, 3, acc);
    k = 0;
    while (w_total < 1 && k < 100) begin @(negedge aclk); #3; k++; end
    vectors++; if (!acc || w_total < 1) begin miscompares++; $display("FAIL rst_mid_reach got=%0d beats exp=1", w_total); end
    @(posedge aclk); #2;
    vectors++; if (m_axi_wvalid !== 1'b1) begin miscompares++; $display("FAIL rst_mid_in_w got=%b exp=1", m_axi_wvalid); end
    aresetn = 0; w_mode = 0;
    #1;
    vectors++; if ({m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid, done} !== 8'h00) begin
      miscompares++; $display("FAIL rst_mid_valids got=%b exp=00000000", {m_axi_awvalid, m_axi_wvalid, m_axi_arvalid, m_axi_bready, m_axi_rready, wr_ready, rd_valid, done}); end
    repeat (2) @(posedge aclk);
    #2 aresetn = 1;
    @(negedge aclk); #3;
    vectors++; if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_cmd_ready got=%b exp=1", cmd_ready); end
    run_cmd(1'b0, 32'h2000 | 32'($urandom_range(511)) << 3, 0, ok);
    vectors++; if (!ok || done_stat !== 2'd0 || w_total != 1 || !bursts_match()) begin
      miscompares++; $display("FAIL rst_mid_recover got=ok%b st%0d beats%0d exp=ok1 st0 beats1", ok, done_stat, w_total); end
  endtask

  task automatic test_random();
    bit ok, w_r;
    logic [31:0] a;
    int n;
    for (int t = 0; t < 12; t++) begin
      wait_pct = $urandom_range(60);
      rresp_rand = 1;
      seed = $urandom;
      for (int i = 0; i < 32; i++) bresp_tab[i] = 2'($urandom_range(3));
      w_r = 1'($urandom_range(1));
      a = $urandom;
      n = $urandom_range(299);
      if (t == 0) begin a = 32'hFFFF_FFF3; n = 3; end
      if (t == 1) begin a = 32'h0000_1003; n = 20; end
      run_cmd(w_r, a, n, ok);
      vectors++; if (!ok) begin miscompares++; $display("FAIL rand%0d_done got=timeout exp=done", t); end
      vectors++; if (!bursts_match()) begin miscompares++; $display("FAIL rand%0d_bursts got=%0d exp=%0d bursts", t, obs_addr_q.size(), exp_addr_q.size()); end
      vectors++; if ((w_r ? rd_cnt : w_total) != n + 1) begin miscompares++; $display("FAIL rand%0d_beats got=%0d exp=%0d", t, w_r ? rd_cnt : w_total, n + 1); end
      vectors++; if (done_stat !== acc_stat || done_cnt != d0 + 1) begin miscompares++; $display("FAIL rand%0d_status got=%0d/%0d exp=%0d/1", t, done_stat, done_cnt - d0, acc_stat); end
    end
    rresp_rand = 0;
  endtask

  task automatic test_max_len();
    bit ok;
    wait_pct = 0;
    run_cmd(1'b1, 32'h8, 4095, ok);
    vectors++; if (!ok || rd_cnt != 4096) begin miscompares++; $display("FAIL max_len_beats got=%0d exp=4096", rd_cnt); end
    vectors++; if (!bursts_match()) begin miscompares++; $display("FAIL max_len_bursts got=%0d exp=%0d bursts", obs_addr_q.size(), exp_addr_q.size()); end
  endtask

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_w_r = 0; cmd_addr = '0; cmd_beats = '0;
    for (int i = 0; i < 32; i++) bresp_tab[i] = 2'd0;
    repeat (3) @(posedge aclk);
    #2 aresetn = 1;
    @(negedge aclk); #3;
    test_reset();
    test_write_simple();
    test_write_4k();
    test_read_long();
    test_read_toggle();
    test_slverr();
    test_reset_midburst();
    test_random();
    test_max_len();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/axi_burst_split_master.md
Name: axi_burst_split_master

Overview:
Parametrised successor of the single-burst AXI master. It accepts one user command of up to 2^LEN_W beats and splits it into AXI INCR bursts. Each burst is capped at MAX_BURST beats and never crosses a 4 KB boundary. Write data is streamed in and read data streamed out with valid/ready backpressure. The block reports one aggregated status per command and sits between user datapath logic and an AXI4 interconnect port.

Parameters:
ADDR_W, 32, address width
DATA_W, 64, data width in bits (power of 2, 32..1024)
LEN_W, 12, width of the user beat count
MAX_BURST, 256, maximum beats per AXI burst (power of 2, 1..256)

Ports:
aclk  in  1  clock
aresetn  in  1  reset; asynchronous assert, active-low
cmd_valid / cmd_ready  in/out  1  command handshake
cmd_w_r  in  1  0 = write, 1 = read
cmd_addr  in  ADDR_W  start byte address; low log2(DATA_W/8) bits forced to 0
cmd_beats  in  LEN_W  beat count minus 1
wr_data / wr_strb  in  DATA_W / DATA_W/8  write stream payload
wr_valid / wr_ready  in/out  1  write stream handshake
rd_data / rd_resp  out  DATA_W / 2  read stream payload
rd_last  out  1  last beat of the command
rd_valid / rd_ready  out/in  1  read stream handshake
done  out  1  one-cycle pulse when the command completes
status  out  2  worst response seen in the command; valid with done
m_axi_aw{addr,len,valid,ready}, m_axi_w{data,strb,last,valid,ready}, m_axi_b{resp,valid,ready}, m_axi_ar{addr,len,valid,ready}, m_axi_r{data,resp,last,valid,ready}  standard AXI4 widths
m_axi_awsize/arsize  out  3  constant log2(DATA_W/8)
m_axi_awburst/arburst  out  2  constant 2'b01

Behaviour:
- Reset: state IDLE; all valid and ready outputs 0; done 0; status 0; addr/len outputs 0; counters 0.
- Reset asserted mid-burst: the block returns to IDLE immediately. No completion of the in-flight AXI transaction is attempted.
- cmd_ready = 1 only in IDLE. On cmd_valid & cmd_ready, latch w_r, aligned addr and remaining = cmd_beats+1. Go to CALC.
- CALC (1 cycle):
  - to4k = (4096 - addr[11:0]) >> log2(DATA_W/8).
  - blen = min(remaining, MAX_BURST, to4k).
  - Register len = blen-1. Go to AW or AR.
- AW: awvalid=1, holding addr/len stable until awready. Then go to W.
- W:
  - wvalid = wr_valid; wr_ready = m_axi_wready. The path is combinational pass-through; no buffering.
  - wlast = 1 on beat counter == len.
  - The beat counter advances on wvalid & wready.
  - Last beat accepted -> B.
- B:
  - bready=1; on bvalid, status = max(status, bresp).
  - addr += blen*DATA_W/8; remaining -= blen.
  - remaining == 0 -> DONE, else -> CALC.
- AR: arvalid=1 until arready. Then go to R.
- R:
  - rd_valid = m_axi_rvalid; m_axi_rready = rd_ready; rd_data/rd_resp pass through.
  - status = max(status, rresp) per accepted beat.
  - rd_last = m_axi_rlast & (remaining == blen).
  - On an accepted beat with rlast, update addr/remaining as in B. Then go to DONE or CALC.
- DONE (1 cycle): done=1, status valid; then return to IDLE with status cleared for the next command.
- Only one burst is outstanding at a time. The AW/AR, W, B and R phases never overlap.
- Stream ready outputs are 0 outside their own phase.
- Response ordering: DECERR(3) > SLVERR(2) > OKAY(0). EXOKAY(1) is treated as OKAY.
- remaining and the counters are LEN_W+1 bits wide, so cmd_beats = all-ones (2^LEN_W beats) is legal.
- Address increments wrap modulo 2^ADDR_W.
- Unaligned cmd_addr is silently aligned down.
- cmd_valid outside IDLE is ignored; cmd_ready stays 0.

Test Plan:
- Write, addr 0x0000, cmd_beats 3, DATA_W 64, zero-wait slave -> one AW, len 3; 4 W beats with wlast on beat 4; done 1 cycle after the B handshake; status 0.
- Write, addr 0x0FF0, cmd_beats 7 -> burst 1 at 0x0FF0 with len 1; burst 2 at 0x1000 with len 5; 8 wr beats total; a single done.
- Read, addr 0x0, cmd_beats 599, MAX_BURST 256 -> ARs at 0x0/len 255, 0x800/len 255, 0x1000/len 87; rd_last only on beat 600.
- Read with rd_ready toggling 1/0 every cycle -> m_axi_rready mirrors it; no beat lost or duplicated; data order preserved.
- Write where burst 1 returns SLVERR and burst 2 returns OKAY -> done with status 2'b10.
- Reset asserted during the W phase of beat 2 -> all valid outputs 0 in the same cycle; after release cmd_ready=1; a new 1-beat write completes with status 0.
